// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared types and constants for the write-back/register-file slice
//
// Purpose: default widths, the register-index type, the x0 index and the
// regSelect encoding, plus a helper that decides whether a write-back request
// actually updates architectural state.
package wb_regfile_pkg;

  localparam int XLEN_DEF   = 32;  // data / register width
  localparam int ADDR_W_DEF = 32;  // instruction address width
  localparam int NREG_DEF   = 32;  // architectural integer registers
  localparam int CNT_W_DEF  = 64;  // retired-writeback counter width
  localparam int REG_IDX_W  = 5;   // register index width

  typedef logic [REG_IDX_W-1:0] reg_index_t;

  localparam reg_index_t REG_ZERO = 5'd0;

  // regSelect_wb encoding
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  // A request naming x0 is architecturally a no-op: no write, no commit, no count.
  // Written so that X on the index cannot leak through while the request is low.
  function automatic logic write_effective(input logic en, input reg_index_t rd);
    if (en == 1'b1) begin
      return (rd != REG_ZERO);
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// rtl/wb_regfile_regfile_2r1w.sv - 2-read/1-write integer register file with x0 rule and write-first bypass
//
// Purpose: NREG x XLEN storage. Index 0 reads as zero and is never written.
// A read that names the register being written this cycle returns the write
// data (write-first), so ID sees WB results without an extra cycle.
//
// Ports:
//   i_clk     in   rising-edge clock
//   i_rst     in   asynchronous active-high reset, clears all registers
//   i_we      in   write enable
//   i_waddr   in   write index
//   i_wdata   in   write data
//   i_raddr1  in   read port 1 index
//   i_raddr2  in   read port 2 index
//   o_rdata1  out  read port 1 data (combinational)
//   o_rdata2  out  read port 2 data (combinational)
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_we;

  // x0 is re-checked here so the storage is safe on its own.
  assign w_we = write_effective(i_we, i_waddr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    if (i_raddr1 == REG_ZERO) begin
      o_rdata1 = '0;
    end else if (w_we && (i_raddr1 == i_waddr)) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (i_raddr2 == REG_ZERO) begin
      o_rdata2 = '0;
    end else if (w_we && (i_raddr2 == i_waddr)) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage: result mux, register file commit, retire counter, commit trace
//
// Purpose: consumes the MEM/WB register outputs, picks the write-back value,
// commits it to the register file, serves ID's two read ports and records a
// registered trace of each commit for debug.
//
// Ports:
//   clk                    in   rising-edge clock
//   rst                    in   asynchronous active-high reset
//   pc_wb                  in   PC of the instruction in WB
//   registerWriteEnable_wb in   write-back request
//   regSelect_wb           in   0 = ALU result, 1 = load data
//   rd_wb                  in   destination register
//   aluSrc_wb              in   ALU result
//   rdData_wb              in   load data
//   rs1_id, rs2_id         in   ID read indices
//   rs1Data_o, rs2Data_o   out  ID read data (combinational, bypassed)
//   wbData_o               out  selected write-back value (combinational)
//   commitValid_o          out  a write committed on the last edge
//   commitPc_o/Rd_o/Data_o out  PC, rd and data of the most recent commit
//   retireCount_o          out  committed writes since reset (wraps)
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_wb,
  input  logic              registerWriteEnable_wb,
  input  logic              regSelect_wb,
  input  logic [4:0]        rd_wb,
  input  logic [XLEN-1:0]   aluSrc_wb,
  input  logic [XLEN-1:0]   rdData_wb,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  output logic [XLEN-1:0]   rs1Data_o,
  output logic [XLEN-1:0]   rs2Data_o,
  output logic [XLEN-1:0]   wbData_o,
  output logic              commitValid_o,
  output logic [ADDR_W-1:0] commitPc_o,
  output logic [4:0]        commitRd_o,
  output logic [XLEN-1:0]   commitData_o,
  output logic [CNT_W-1:0]  retireCount_o
);

  logic [XLEN-1:0]   w_wb_data;
  logic              w_we;

  logic              r_commit_valid;
  logic [ADDR_W-1:0] r_commit_pc;
  logic [4:0]        r_commit_rd;
  logic [XLEN-1:0]   r_commit_data;
  logic [CNT_W-1:0]  r_retire_count;

  assign w_wb_data = (regSelect_wb == WB_SEL_MEM) ? rdData_wb : aluSrc_wb;
  assign w_we      = write_effective(registerWriteEnable_wb, rd_wb);

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (w_we),
    .i_waddr  (rd_wb),
    .i_wdata  (w_wb_data),
    .i_raddr1 (rs1_id),
    .i_raddr2 (rs2_id),
    .o_rdata1 (rs1Data_o),
    .o_rdata2 (rs2Data_o)
  );

  // Valid pulses per commit; the payload holds the last commit so the
  // trace still shows it across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
      r_retire_count <= '0;
    end else begin
      r_commit_valid <= w_we;
      if (w_we) begin
        r_commit_pc    <= pc_wb;
        r_commit_rd    <= rd_wb;
        r_commit_data  <= w_wb_data;
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wbData_o      = w_wb_data;
  assign commitValid_o = r_commit_valid;
  assign commitPc_o    = r_commit_pc;
  assign commitRd_o    = r_commit_rd;
  assign commitData_o  = r_commit_data;
  assign retireCount_o = r_retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_wb;
  logic        registerWriteEnable_wb;
  logic        regSelect_wb;
  logic [4:0]  rd_wb;
  logic [31:0] aluSrc_wb;
  logic [31:0] rdData_wb;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [31:0] rs1Data_o;
  logic [31:0] rs2Data_o;
  logic [31:0] wbData_o;
  logic        commitValid_o;
  logic [31:0] commitPc_o;
  logic [4:0]  commitRd_o;
  logic [31:0] commitData_o;
  logic [63:0] retireCount_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model of architectural state
  logic [31:0] m_regs [32];
  logic [63:0] m_count;
  logic        m_cv;
  logic [31:0] m_cpc;
  logic [4:0]  m_crd;
  logic [31:0] m_cdata;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk                    (clk),
    .rst                    (rst),
    .pc_wb                  (pc_wb),
    .registerWriteEnable_wb (registerWriteEnable_wb),
    .regSelect_wb           (regSelect_wb),
    .rd_wb                  (rd_wb),
    .aluSrc_wb              (aluSrc_wb),
    .rdData_wb              (rdData_wb),
    .rs1_id                 (rs1_id),
    .rs2_id                 (rs2_id),
    .rs1Data_o              (rs1Data_o),
    .rs2Data_o              (rs2Data_o),
    .wbData_o               (wbData_o),
    .commitValid_o          (commitValid_o),
    .commitPc_o             (commitPc_o),
    .commitRd_o             (commitRd_o),
    .commitData_o           (commitData_o),
    .retireCount_o          (retireCount_o)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_count = 64'h0;
    m_cv    = 1'b0;
    m_cpc   = 32'h0;
    m_crd   = 5'h0;
    m_cdata = 32'h0;
  endtask

  function automatic logic m_we();
    if (registerWriteEnable_wb === 1'b1 && rd_wb != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_wbval();
    return regSelect_wb ? rdData_wb : aluSrc_wb;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (m_we() && idx == rd_wb) return m_wbval();
    return m_regs[idx];
  endfunction

  // advance one rising edge, applying the architectural effect to the model
  task automatic clock_edge();
    logic        w;
    logic [31:0] v;
    logic [31:0] p;
    logic [4:0]  r;
    w = m_we();
    v = m_wbval();
    p = pc_wb;
    r = rd_wb;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_cv = w;
      if (w) begin
        m_regs[r] = v;
        m_count   = m_count + 64'd1;
        m_cpc     = p;
        m_crd     = r;
        m_cdata   = v;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    registerWriteEnable_wb = 1'b0;
    regSelect_wb           = 1'b0;
    rd_wb                  = 5'd0;
    aluSrc_wb              = 32'h0;
    rdData_wb              = 32'h0;
    pc_wb                  = 32'h0;
    rs1_id                 = 5'd0;
    rs2_id                 = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_id = 5'(i);
      rs2_id = 5'(31 - i);
      #1;
      total_cnt++;
      if (rs1Data_o !== 32'h0 || rs2Data_o !== 32'h0)
        $display("FAIL reset_read idx=%0d got rs1=%h rs2=%h expected 0", i, rs1Data_o, rs2Data_o);
      else pass_cnt++;
    end
    total_cnt++;
    if (commitValid_o !== 1'b0 || retireCount_o !== 64'h0)
      $display("FAIL reset_state got cv=%b cnt=%0d expected cv=0 cnt=0", commitValid_o, retireCount_o);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) clock_edge();
    rs1_id = 5'd17;
    #1;
    total_cnt++;
    if (commitValid_o !== 1'b0 || retireCount_o !== 64'h0 || rs1Data_o !== 32'h0 || commitPc_o !== 32'h0)
      $display("FAIL reset_idle got cv=%b cnt=%0d rs1=%h pc=%h expected all 0",
               commitValid_o, retireCount_o, rs1Data_o, commitPc_o);
    else pass_cnt++;
  endtask

  task automatic test_alu_wb();
    pc_wb                  = 32'h0000_0100;
    registerWriteEnable_wb = 1'b1;
    regSelect_wb           = 1'b0;
    rd_wb                  = 5'd5;
    aluSrc_wb              = 32'h1234_5678;
    rdData_wb              = $urandom;
    #1;
    total_cnt++;
    if (wbData_o !== 32'h1234_5678)
      $display("FAIL alu_mux got %h expected 12345678", wbData_o);
    else pass_cnt++;
    clock_edge();
    registerWriteEnable_wb = 1'b0;
    rs1_id = 5'd5;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'h1234_5678)
      $display("FAIL alu_read got %h expected 12345678", rs1Data_o);
    else pass_cnt++;
    total_cnt++;
    if (commitValid_o !== 1'b1 || commitRd_o !== 5'd5 || commitPc_o !== 32'h100 ||
        commitData_o !== 32'h1234_5678 || retireCount_o !== 64'd1)
      $display("FAIL alu_commit got cv=%b rd=%0d pc=%h d=%h cnt=%0d expected 1 5 100 12345678 1",
               commitValid_o, commitRd_o, commitPc_o, commitData_o, retireCount_o);
    else pass_cnt++;
  endtask

  task automatic test_load_bypass();
    pc_wb                  = 32'h0000_0104;
    registerWriteEnable_wb = 1'b1;
    regSelect_wb           = 1'b1;
    rd_wb                  = 5'd7;
    rdData_wb              = 32'hDEAD_BEEF;
    aluSrc_wb              = 32'h1;
    rs1_id                 = 5'd7;
    rs2_id                 = 5'd7;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'hDEAD_BEEF || rs2Data_o !== 32'hDEAD_BEEF || wbData_o !== 32'hDEAD_BEEF)
      $display("FAIL load_bypass got rs1=%h rs2=%h wb=%h expected deadbeef", rs1Data_o, rs2Data_o, wbData_o);
    else pass_cnt++;
    clock_edge();
    registerWriteEnable_wb = 1'b0;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'hDEAD_BEEF || retireCount_o !== 64'd2)
      $display("FAIL load_stored got rs1=%h cnt=%0d expected deadbeef 2", rs1Data_o, retireCount_o);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    pc_wb                  = 32'h0000_0108;
    registerWriteEnable_wb = 1'b1;
    regSelect_wb           = 1'b0;
    rd_wb                  = 5'd0;
    aluSrc_wb              = 32'hFFFF_FFFF;
    rs1_id                 = 5'd0;
    rs2_id                 = 5'd0;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'h0 || rs2Data_o !== 32'h0)
      $display("FAIL x0_bypass got rs1=%h rs2=%h expected 0", rs1Data_o, rs2Data_o);
    else pass_cnt++;
    clock_edge();
    registerWriteEnable_wb = 1'b0;
    #1;
    total_cnt++;
    if (commitValid_o !== 1'b0 || retireCount_o !== 64'd2 || commitPc_o !== 32'h104 || commitRd_o !== 5'd7)
      $display("FAIL x0_commit got cv=%b cnt=%0d pc=%h rd=%0d expected 0 2 104 7",
               commitValid_o, retireCount_o, commitPc_o, commitRd_o);
    else pass_cnt++;
    total_cnt++;
    if (rs1Data_o !== 32'h0)
      $display("FAIL x0_after got %h expected 0", rs1Data_o);
    else pass_cnt++;
  endtask

  task automatic test_disabled();
    registerWriteEnable_wb = 1'b0;
    regSelect_wb           = 1'b0;
    rd_wb                  = 5'd3;
    aluSrc_wb              = 32'hAAAA_AAAA;
    rdData_wb              = 'x;
    rs2_id                 = 5'd3;
    #1;
    total_cnt++;
    if (rs2Data_o !== 32'h0)
      $display("FAIL disabled_read got %h expected 0", rs2Data_o);
    else pass_cnt++;
    clock_edge();
    // garbage inputs while disabled must not disturb anything
    regSelect_wb = 'x;
    rd_wb        = 'x;
    aluSrc_wb    = 'x;
    pc_wb        = 'x;
    clock_edge();
    rd_wb = 5'd3;
    #1;
    total_cnt++;
    if (rs2Data_o !== 32'h0 || commitValid_o !== 1'b0 || commitRd_o !== 5'd7 ||
        commitData_o !== 32'hDEAD_BEEF || commitPc_o !== 32'h104 || retireCount_o !== 64'd2)
      $display("FAIL disabled_hold got rs2=%h cv=%b rd=%0d d=%h pc=%h cnt=%0d expected 0 0 7 deadbeef 104 2",
               rs2Data_o, commitValid_o, commitRd_o, commitData_o, commitPc_o, retireCount_o);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 300; n++) begin
      pc_wb                  = $urandom;
      registerWriteEnable_wb = 1'($urandom_range(0, 1));
      regSelect_wb           = 1'($urandom_range(0, 1));
      rd_wb                  = 5'($urandom_range(0, 31));
      aluSrc_wb              = $urandom;
      rdData_wb              = $urandom;
      rs1_id                 = ($urandom_range(0, 3) == 0) ? rd_wb : 5'($urandom_range(0, 31));
      rs2_id                 = ($urandom_range(0, 3) == 0) ? rd_wb : 5'($urandom_range(0, 31));
      #1;
      total_cnt++;
      if (rs1Data_o !== m_read(rs1_id) || rs2Data_o !== m_read(rs2_id) || wbData_o !== m_wbval()) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_read n=%0d rs1=%0d got %h exp %h rs2=%0d got %h exp %h wb got %h exp %h",
                   n, rs1_id, rs1Data_o, m_read(rs1_id), rs2_id, rs2Data_o, m_read(rs2_id), wbData_o, m_wbval());
      end else pass_cnt++;
      clock_edge();
      total_cnt++;
      if (commitValid_o !== m_cv || retireCount_o !== m_count || commitPc_o !== m_cpc ||
          commitRd_o !== m_crd || commitData_o !== m_cdata) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_commit n=%0d got cv=%b cnt=%0d pc=%h rd=%0d d=%h exp cv=%b cnt=%0d pc=%h rd=%0d d=%h",
                   n, commitValid_o, retireCount_o, commitPc_o, commitRd_o, commitData_o,
                   m_cv, m_count, m_cpc, m_crd, m_cdata);
      end else pass_cnt++;
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 2; r++) begin
      registerWriteEnable_wb = 1'b1;
      regSelect_wb           = 1'b0;
      rd_wb                  = 5'(r);
      aluSrc_wb              = 32'h1000 + r;
      pc_wb                  = 32'h200 + 4 * r;
      clock_edge();
    end
    // x3 write in flight; reset rises between edges
    rd_wb     = 5'd3;
    aluSrc_wb = 32'h1003;
    pc_wb     = 32'h20C;
    rs1_id    = 5'd1;
    rs2_id    = 5'd2;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'h0 || rs2Data_o !== 32'h0 || retireCount_o !== 64'h0 || commitValid_o !== 1'b0)
      $display("FAIL async_reset got rs1=%h rs2=%h cnt=%0d cv=%b expected 0",
               rs1Data_o, rs2Data_o, retireCount_o, commitValid_o);
    else pass_cnt++;
    clock_edge();
    rst = 1'b0;
    registerWriteEnable_wb = 1'b0;
    rs1_id = 5'd3;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'h0 || retireCount_o !== 64'h0 || commitValid_o !== 1'b0)
      $display("FAIL async_discard got x3=%h cnt=%0d cv=%b expected 0", rs1Data_o, retireCount_o, commitValid_o);
    else pass_cnt++;
    registerWriteEnable_wb = 1'b1;
    rd_wb     = 5'd9;
    aluSrc_wb = 32'h42;
    pc_wb     = 32'h300;
    clock_edge();
    registerWriteEnable_wb = 1'b0;
    rs1_id = 5'd9;
    #1;
    total_cnt++;
    if (rs1Data_o !== 32'h42 || retireCount_o !== 64'd1 || commitValid_o !== 1'b1 || commitRd_o !== 5'd9)
      $display("FAIL async_resume got x9=%h cnt=%0d cv=%b rd=%0d expected 42 1 1 9",
               rs1Data_o, retireCount_o, commitValid_o, commitRd_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load_bypass();
    test_x0();
    test_disabled();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface; consumes the MEM/WB register outputs.
- Selects the write-back value, commits it into the 32x32 integer register file, and serves the ID stage's two read ports with same-cycle write bypass.
- Keeps a retired-writeback counter and a registered commit trace for the debug/verification bench.

Parameters:
- XLEN, 32, data/register width (matches `data).
- ADDR_W, 32, PC width (matches `instructionAddrPath).
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pc_wb  in  ADDR_W  PC of the instruction in WB.
- registerWriteEnable_wb  in  1  write-back request.
- regSelect_wb  in  1  0 = ALU result, 1 = load data.
- rd_wb  in  5  destination register index.
- aluSrc_wb  in  XLEN  ALU result from MEM/WB.
- rdData_wb  in  XLEN  load data from MEM/WB.
- rs1_id  in  5  read port 1 index.
- rs2_id  in  5  read port 2 index.
- rs1Data_o  out  XLEN  read port 1 data, combinational.
- rs2Data_o  out  XLEN  read port 2 data, combinational.
- wbData_o  out  XLEN  selected write-back value, combinational (forwarding source for EX).
- commitValid_o  out  1  registered: a write committed last cycle.
- commitPc_o  out  ADDR_W  registered PC of last commit.
- commitRd_o  out  5  registered rd of last commit.
- commitData_o  out  XLEN  registered data of last commit.
- retireCount_o  out  CNT_W  number of committed writes since reset.

Behaviour:
- Reset (async, rst=1): all NREG registers, the commit* outputs and retireCount_o clear to 0 immediately. They hold at 0 while rst is high.
- Write-back mux: wbData_o = regSelect_wb ? rdData_wb : aluSrc_wb. This is pure combinational logic with 0 latency.
- Effective write: we = registerWriteEnable_wb && (rd_wb != 0). On a rising edge with we=1, regs[rd_wb] <= wbData_o.
- x0: never written. Reads of index 0 always return 0, even under bypass.
- Read ports:
  - rsN_id == 0 -> 0.
  - else if we && rsN_id == rd_wb -> wbData_o (write-first bypass, same cycle).
  - else regs[rsN_id].
  - Both ports are independent; both may hit the bypass simultaneously.
- Commit trace, updated every rising edge:
  - commitValid_o <= we.
  - When we=1: commitPc_o <= pc_wb, commitRd_o <= rd_wb, commitData_o <= wbData_o.
  - When we=0: the previous values are held.
- Counter: retireCount_o increments by 1 on each edge with we=1. It wraps modulo 2^CNT_W with no saturation.
- registerWriteEnable_wb=1 with rd_wb=0: no write, no commit, no count. The bypass does not apply.
- Inputs that are X while registerWriteEnable_wb=0 must not corrupt state.
- Reset asserted mid-stream: any write pending at that edge is discarded. The first write after rst deasserts behaves normally.
- There is no internal state machine beyond storage/counter. There is no stall input: MEM/WB stalls are expressed by deasserting registerWriteEnable_wb.

Decomposition:
- Shared package/Types.v holds:
  - `data, `instructionAddrPath, and a new `regIndex (5-bit) macro.
  - Constant REG_ZERO = 5'd0.
  - WB_SEL_ALU = 1'b0 and WB_SEL_MEM = 1'b1 for regSelect encoding.
- One sub-module is natural: regfile_2r1w (storage, x0 rule, bypass).
- The top wb_regfile adds the mux, the commit trace and the counter.

Test Plan:
- Reset: hold rst=1, read all 32 indices -> all 0; commitValid_o=0 and retireCount_o=0. Deassert rst, idle 3 cycles -> unchanged.
- ALU write-back: we=1, regSelect=0, rd=5, aluSrc=0x1234_5678.
  - Next cycle rs1=5 reads 0x1234_5678.
  - commitValid_o=1, commitRd_o=5, commitPc_o equals the applied pc_wb.
  - retireCount_o=1.
- Load write-back with bypass: regSelect=1, rd=7, rdData=0xDEAD_BEEF, aluSrc=0x1, rs1=rs2=7 in the same cycle.
  - Both read ports return 0xDEAD_BEEF before the edge.
  - regs[7]=0xDEAD_BEEF after the edge.
- x0 protection: we=1, rd=0, aluSrc=0xFFFF_FFFF, rs1=0.
  - rs1Data_o=0 and x0 stays 0.
  - commitValid_o=0 next cycle; retireCount_o unchanged.
- Disabled write: we=0, rd=3, aluSrc=0xAAAA_AAAA, rs2=3 -> rs2Data_o shows the old regs[3] (0); no change after the edge; the commit* values hold.
- Async reset mid-operation: back-to-back writes to x1..x4, with rst pulsed high between edges during the x3 write.
  - All regs and the counter read 0 immediately.
  - After release, writing x9=0x42 gives retireCount_o=1 and regs[9]=0x42.
